// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the 7-segment digit source.
package seven_segment_pkg;

  localparam int unsigned DIGIT_BITS         = 4;
  localparam int unsigned BCD_ADD3_THRESHOLD = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Double-dabble correction: a nibble that would reach 10 or more after the shift gets +3 first.
  function automatic logic [DIGIT_BITS-1:0] bcd_adjust(input logic [DIGIT_BITS-1:0] nib);
    return (nib >= DIGIT_BITS'(BCD_ADD3_THRESHOLD)) ? nib + DIGIT_BITS'(3) : nib;
  endfunction

endpackage

// File: rtl/seven_segment_digit_source_if.sv
// Value-in / digits-out bundle between the value producer and the digit source.
interface seven_segment_digit_source_if
  import seven_segment_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);

  logic [WIDTH-1:0]             I_VALUE;
  logic                         I_DECIMAL;
  logic                         I_VALID;
  logic                         O_READY;
  logic [DIGIT_BITS*DIGITS-1:0] O_DIGITS;
  logic [DIGITS-1:0]            O_BLANK;
  logic                         O_DIGITS_VALID;

  modport slave (
    input  I_VALUE, I_DECIMAL, I_VALID,
    output O_READY, O_DIGITS, O_BLANK, O_DIGITS_VALID
  );

  modport master (
    output I_VALUE, I_DECIMAL, I_VALID,
    input  O_READY, O_DIGITS, O_BLANK, O_DIGITS_VALID
  );

endinterface

// File: rtl/binary_to_bcd_serial.sv
// Serial double-dabble converter: one shift per cycle, WIDTH cycles per conversion.
module binary_to_bcd_serial
  import seven_segment_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [WIDTH-1:0]             value_i,
  output logic                         busy_o,
  output logic                         last_o,
  output logic                         done_o,
  output logic [DIGIT_BITS*DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = DIGIT_BITS * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj[i*DIGIT_BITS +: DIGIT_BITS] = bcd_adjust(bcd_q[i*DIGIT_BITS +: DIGIT_BITS]);
    end
  end

  // last_q is high in the cycle whose closing edge performs the final shift.
  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    last_d  = 1'b0;
    done_d  = 1'b0;
    if (start_i) begin
      shift_d = value_i;
      bcd_d   = '0;
      cnt_d   = CNT_W'(WIDTH);
      busy_d  = 1'b1;
      last_d  = (WIDTH == 1);
    end else if (busy_q) begin
      {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
      last_d = (cnt_q == CNT_W'(2));
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign last_o = last_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seven_segment_digit_source.sv
// Turns a binary value into per-display hex or decimal digits plus a leading-zero blank mask.
module seven_segment_digit_source
  import seven_segment_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                         I_CLK,
  input  logic                         I_NRESET,
  seven_segment_digit_source_if.slave  sink
);

  localparam int unsigned DIG_W = DIGIT_BITS * DIGITS;

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic               accept_c;
  logic               bcd_start;
  logic               bcd_busy;
  logic               bcd_last;
  logic               bcd_done;
  logic [DIG_W-1:0]   bcd_value;

  // Digit i is blanked when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] blank_of(input logic [DIG_W-1:0] d);
    logic seen;
    blank_of = '0;
    seen     = 1'b0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      seen        = seen | (d[i*DIGIT_BITS +: DIGIT_BITS] != '0);
      blank_of[i] = !seen;
    end
  endfunction

  binary_to_bcd_serial #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk     (I_CLK),
    .rst_n   (I_NRESET),
    .start_i (bcd_start),
    .value_i (sink.I_VALUE),
    .busy_o  (bcd_busy),
    .last_o  (bcd_last),
    .done_o  (bcd_done),
    .bcd_o   (bcd_value)
  );

  assign accept_c = sink.I_VALID && ready_q;

  // Digits and blank mask only change on a hex accept or at the end of a conversion.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    valid_d   = 1'b0;
    ready_d   = ready_q;
    bcd_start = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept_c) begin
          if (!sink.I_DECIMAL) begin
            digits_d = DIG_W'(sink.I_VALUE);
            valid_d  = 1'b1;
          end else begin
            bcd_start = 1'b1;
            ready_d   = 1'b0;
            state_d   = CONVERT;
          end
        end
      end
      CONVERT: begin
        if (bcd_busy && bcd_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bcd_done) begin
          digits_d = bcd_value;
          valid_d  = 1'b1;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    blank_d = blank_of(digits_d);
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q  <= IDLE;
      digits_q <= '0;
      blank_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign sink.O_READY        = ready_q;
  assign sink.O_DIGITS       = digits_q;
  assign sink.O_BLANK        = blank_q;
  assign sink.O_DIGITS_VALID = valid_q;

endmodule

// File: tb/tb_seven_segment_digit_source.sv
// Self-checking bench for seven_segment_digit_source (WIDTH=16, DIGITS=5).
module tb_seven_segment_digit_source;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 5;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [19:0] exp_prev;

  seven_segment_digit_source_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  seven_segment_digit_source #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .I_CLK    (clk),
    .I_NRESET (rst_n),
    .sink     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    bit          dec;
    logic [19:0] digits;
    logic [4:0]  blank;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: digits by repeated division in the chosen base.
  function automatic logic [19:0] model_digits(input logic [15:0] v, input bit dec);
    int unsigned x;
    logic [19:0] r;
    x = v;
    r = '0;
    if (!dec) return 20'(v);
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: every position above the number's significant-digit count is blanked.
  function automatic logic [4:0] model_blank(input logic [15:0] v, input bit dec);
    int unsigned x, base, n;
    x    = v;
    base = dec ? 10 : 16;
    n    = 1;
    while (x >= base) begin
      x = x / base;
      n++;
    end
    return 5'(~((32'd1 << n) - 32'd1));
  endfunction

  // Waits for the result pulse, checking that the display held and O_READY stayed low meanwhile.
  task automatic wait_result(output int edges, output bit hold_ok);
    edges   = 0;
    hold_ok = 1'b1;
    while (bus.O_DIGITS_VALID !== 1'b1 && edges < 40) begin
      if (bus.O_READY !== 1'b0 || bus.O_DIGITS !== exp_prev) hold_ok = 1'b0;
      step();
      edges++;
    end
  endtask

  task automatic send(input logic [15:0] v, input bit dec, input logic [19:0] exp_d,
                      input logic [4:0] exp_b, input string tag);
    int edges;
    bit hold_ok;
    chk({tag, "_ready_before"}, 32'(bus.O_READY), 32'd1);
    bus.I_VALUE   = v;
    bus.I_DECIMAL = dec;
    bus.I_VALID   = 1'b1;
    step();
    bus.I_VALID = 1'b0;
    if (dec) begin
      wait_result(edges, hold_ok);
      chk({tag, "_latency"}, 32'(edges), 32'd17);
      chk({tag, "_hold_busy"}, 32'(hold_ok), 32'd1);
    end else begin
      chk({tag, "_hex_valid"}, 32'(bus.O_DIGITS_VALID), 32'd1);
    end
    chk({tag, "_digits"}, 32'(bus.O_DIGITS), 32'(exp_d));
    chk({tag, "_blank"}, 32'(bus.O_BLANK), 32'(exp_b));
    chk({tag, "_ready_after"}, 32'(bus.O_READY), 32'd1);
    exp_prev = exp_d;
    step();
    chk({tag, "_single_pulse"}, 32'(bus.O_DIGITS_VALID), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    bit hold_ok;
    bit quiet;
    logic [15:0] v;
    bit dec;

    n_tests  = 0;
    n_fail   = 0;
    exp_prev = '0;
    bus.I_VALUE   = '0;
    bus.I_DECIMAL = 1'b0;
    bus.I_VALID   = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{16'hBEEF, 1'b0, 20'h0BEEF, 5'b10000};
    vecs[1] = '{16'h0007, 1'b0, 20'h00007, 5'b11110};
    vecs[2] = '{16'd65535, 1'b1, 20'h65535, 5'b00000};
    vecs[3] = '{16'd1234, 1'b1, 20'h01234, 5'b10000};
    vecs[4] = '{16'd0, 1'b1, 20'h00000, 5'b11110};
    vecs[5] = '{16'd9999, 1'b1, 20'h09999, 5'b10000};
    vecs[6] = '{16'h0000, 1'b0, 20'h00000, 5'b11110};
    vecs[7] = '{16'h1000, 1'b0, 20'h01000, 5'b10000};
    vecs[8] = '{16'd10, 1'b1, 20'h00010, 5'b11100};
    vecs[9] = '{16'hFFFF, 1'b0, 20'h0FFFF, 5'b10000};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_digits", 32'(bus.O_DIGITS), 32'h0);
    chk("reset_blank", 32'(bus.O_BLANK), 32'b11110);
    chk("reset_ready", 32'(bus.O_READY), 32'd1);
    chk("reset_valid", 32'(bus.O_DIGITS_VALID), 32'd0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].value, vecs[i].dec, vecs[i].digits, vecs[i].blank, $sformatf("vec%0d", i));
    end

    // Back-to-back hex accepts on consecutive edges.
    bus.I_VALUE = 16'hBEEF; bus.I_DECIMAL = 1'b0; bus.I_VALID = 1'b1;
    step();
    chk("b2b_first_digits", 32'(bus.O_DIGITS), 32'h0BEEF);
    chk("b2b_first_blank", 32'(bus.O_BLANK), 32'b10000);
    chk("b2b_first_valid", 32'(bus.O_DIGITS_VALID), 32'd1);
    chk("b2b_first_ready", 32'(bus.O_READY), 32'd1);
    bus.I_VALUE = 16'h0007;
    step();
    bus.I_VALID = 1'b0;
    chk("b2b_second_digits", 32'(bus.O_DIGITS), 32'h00007);
    chk("b2b_second_blank", 32'(bus.O_BLANK), 32'b11110);
    chk("b2b_second_valid", 32'(bus.O_DIGITS_VALID), 32'd1);
    step();
    chk("b2b_valid_drop", 32'(bus.O_DIGITS_VALID), 32'd0);
    exp_prev = 20'h00007;

    // Valid held high with a new value while busy: ignored until ready returns.
    bus.I_VALUE = 16'd1234; bus.I_DECIMAL = 1'b1; bus.I_VALID = 1'b1;
    step();
    bus.I_VALUE = 16'd9999;
    wait_result(edges, hold_ok);
    chk("held_1234_latency", 32'(edges), 32'd17);
    chk("held_1234_hold", 32'(hold_ok), 32'd1);
    chk("held_1234_digits", 32'(bus.O_DIGITS), 32'h01234);
    chk("held_1234_blank", 32'(bus.O_BLANK), 32'b10000);
    chk("held_1234_ready", 32'(bus.O_READY), 32'd1);
    exp_prev = 20'h01234;
    step();
    bus.I_VALID = 1'b0;
    wait_result(edges, hold_ok);
    chk("held_9999_latency", 32'(edges), 32'd17);
    chk("held_9999_hold", 32'(hold_ok), 32'd1);
    chk("held_9999_digits", 32'(bus.O_DIGITS), 32'h09999);
    chk("held_9999_blank", 32'(bus.O_BLANK), 32'b10000);
    exp_prev = 20'h09999;
    step();

    // Asynchronous reset in the middle of a decimal conversion.
    bus.I_VALUE = 16'd40000; bus.I_DECIMAL = 1'b1; bus.I_VALID = 1'b1;
    step();
    bus.I_VALID = 1'b0;
    repeat (8) step();
    chk("midrst_busy_before", 32'(bus.O_READY), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_digits", 32'(bus.O_DIGITS), 32'h0);
    chk("midrst_blank", 32'(bus.O_BLANK), 32'b11110);
    chk("midrst_ready", 32'(bus.O_READY), 32'd1);
    chk("midrst_valid", 32'(bus.O_DIGITS_VALID), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.O_DIGITS_VALID !== 1'b0) quiet = 1'b0;
      if (i == 2) rst_n = 1'b1;
    end
    chk("midrst_no_pulse", 32'(quiet), 32'd1);
    exp_prev = '0;
    send(16'd40000, 1'b1, 20'h40000, 5'b00000, "after_rst");

    // Randomized traffic against the arithmetic reference model.
    for (int t = 0; t < 150; t++) begin
      v   = 16'($urandom);
      dec = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: v = 16'd0;
        1: v = 16'hFFFF;
        2: v = 16'($urandom_range(0, 99));
        default: ;
      endcase
      send(v, dec, model_digits(v, dec), model_blank(v, dec), $sformatf("rand%0d", t));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
